// File: rtl/aes_cmd_sequencer.sv
// Command sequencer in front of the AES core: turns key-expand / encrypt / decrypt
// commands into single-cycle core strobes and returns exactly one response per command.
module aes_cmd_sequencer #(
   parameter int KEY_S          = 256,
   parameter int BLK_S          = 128,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             s_cmd_valid,
   output logic             s_cmd_ready,
   input  logic [1:0]       s_cmd_op,
   input  logic             s_cmd_mode,
   input  logic [KEY_S-1:0] s_cmd_data,
   output logic             m_out_valid,
   input  logic             m_out_ready,
   output logic [BLK_S-1:0] m_out_data,
   output logic [1:0]       m_out_status,
   output logic             key_valid,
   output logic             en_key,
   output logic             en_cipher,
   output logic             en_decipher,
   output logic             aes128_mode,
   output logic             aes256_mode,
   output logic [KEY_S-1:0] aes_key,
   output logic [BLK_S-1:0] aes_in_blk,
   input  logic [BLK_S-1:0] aes_out_blk,
   input  logic             en_o,
   input  logic             aes_op_in_progress
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   localparam logic [1:0] OP_KEY = 2'b00;
   localparam logic [1:0] OP_ENC = 2'b01;
   localparam logic [1:0] OP_DEC = 2'b10;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_NOKEY   = 2'b01;
   localparam logic [1:0] ST_BADOP   = 2'b10;
   localparam logic [1:0] ST_TIMEOUT = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t             state_r, state_s;
   logic [1:0]         op_r, op_s;
   logic [CNT_W-1:0]   cnt_r, cnt_s, cnt_inc_s;
   logic               ready_r, ready_s;
   logic               valid_r, valid_s;
   logic [BLK_S-1:0]   data_r, data_s;
   logic [1:0]         status_r, status_s;
   logic               kv_r, kv_s;
   logic [KEY_S-1:0]   key_r, key_s;
   logic [BLK_S-1:0]   blk_r, blk_s;
   logic               m128_r, m128_s;
   logic               m256_r, m256_s;
   logic [2:0]         strobe_r, strobe_s;   // {en_decipher, en_cipher, en_key}

   function automatic logic [2:0] strobe_for_op(input logic [1:0] op);
      case (op)
         OP_KEY:  return 3'b001;
         OP_ENC:  return 3'b010;
         OP_DEC:  return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   // Next-state and next-output logic of the command FSM
   always_comb begin
      state_s   = state_r;
      op_s      = op_r;
      cnt_s     = cnt_r;
      valid_s   = valid_r;
      data_s    = data_r;
      status_s  = status_r;
      kv_s      = kv_r;
      key_s     = key_r;
      blk_s     = blk_r;
      m128_s    = m128_r;
      m256_s    = m256_r;
      strobe_s  = 3'b000;
      ready_s   = 1'b0;
      cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
      case (state_r)
         IDLE: begin
            if (s_cmd_valid && ready_r) begin
               op_s = s_cmd_op;
               case (s_cmd_op)
                  OP_KEY: begin
                     key_s   = s_cmd_data;
                     m128_s  = ~s_cmd_mode;
                     m256_s  = s_cmd_mode;
                     kv_s    = 1'b0;
                     state_s = ISSUE;
                  end
                  OP_ENC, OP_DEC: begin
                     blk_s = s_cmd_data[BLK_S-1:0];
                     if (kv_r) begin
                        state_s = ISSUE;
                     end else begin
                        state_s  = RESP;
                        valid_s  = 1'b1;
                        status_s = ST_NOKEY;
                        data_s   = {BLK_S{1'b0}};
                     end
                  end
                  default: begin
                     state_s  = RESP;
                     valid_s  = 1'b1;
                     status_s = ST_BADOP;
                     data_s   = {BLK_S{1'b0}};
                  end
               endcase
               // Registered strobe: fire in the first ISSUE cycle when the core is idle now
               if ((state_s == ISSUE) && !aes_op_in_progress) begin
                  strobe_s = strobe_for_op(s_cmd_op);
               end else begin
                  strobe_s = 3'b000;
               end
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            if (strobe_r != 3'b000) begin
               state_s = WAIT;
               cnt_s   = CNT_ZERO;
            end else if (!aes_op_in_progress) begin
               strobe_s = strobe_for_op(op_r);
            end else begin
               state_s = ISSUE;
            end
         end
         WAIT: begin
            cnt_s = cnt_inc_s;
            // Completion takes priority over the terminal count
            if (en_o) begin
               state_s  = RESP;
               valid_s  = 1'b1;
               status_s = ST_OK;
               data_s   = (op_r == OP_KEY) ? {BLK_S{1'b0}} : aes_out_blk;
               kv_s     = (op_r == OP_KEY) ? 1'b1 : kv_r;
            end else if (cnt_inc_s == CNT_MAX) begin
               state_s  = RESP;
               valid_s  = 1'b1;
               status_s = ST_TIMEOUT;
               data_s   = {BLK_S{1'b0}};
               kv_s     = 1'b0;
            end else begin
               state_s = WAIT;
            end
         end
         RESP: begin
            if (m_out_ready) begin
               valid_s = 1'b0;
               state_s = IDLE;
            end else begin
               state_s = RESP;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      ready_s = (state_s == IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r  <= IDLE;
         op_r     <= 2'b00;
         cnt_r    <= CNT_ZERO;
         ready_r  <= 1'b0;
         valid_r  <= 1'b0;
         data_r   <= {BLK_S{1'b0}};
         status_r <= 2'b00;
         kv_r     <= 1'b0;
         key_r    <= {KEY_S{1'b0}};
         blk_r    <= {BLK_S{1'b0}};
         m128_r   <= 1'b0;
         m256_r   <= 1'b0;
         strobe_r <= 3'b000;
      end else begin
         state_r  <= state_s;
         op_r     <= op_s;
         cnt_r    <= cnt_s;
         ready_r  <= ready_s;
         valid_r  <= valid_s;
         data_r   <= data_s;
         status_r <= status_s;
         kv_r     <= kv_s;
         key_r    <= key_s;
         blk_r    <= blk_s;
         m128_r   <= m128_s;
         m256_r   <= m256_s;
         strobe_r <= strobe_s;
      end
   end

   assign s_cmd_ready  = ready_r;
   assign m_out_valid  = valid_r;
   assign m_out_data   = data_r;
   assign m_out_status = status_r;
   assign key_valid    = kv_r;
   assign en_key       = strobe_r[0];
   assign en_cipher    = strobe_r[1];
   assign en_decipher  = strobe_r[2];
   assign aes128_mode  = m128_r;
   assign aes256_mode  = m256_r;
   assign aes_key      = key_r;
   assign aes_in_blk   = blk_r;

endmodule

// File: tb/tb_aes_cmd_sequencer.sv
// Bench for aes_cmd_sequencer: a stub AES core with known-answer vectors plus a
// command-level reference model; directed steps followed by randomized commands.
`timescale 1ns/1ps
module tb_aes_cmd_sequencer;
   localparam int TO = 64;
   localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] MIXC  = 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;

   logic clk = 1'b0, reset = 1'b0;
   logic s_cmd_valid = 1'b0, s_cmd_ready, s_cmd_mode = 1'b0;
   logic [1:0] s_cmd_op = 2'b00;
   logic [255:0] s_cmd_data = '0;
   logic m_out_valid, m_out_ready = 1'b0;
   logic [127:0] m_out_data;
   logic [1:0] m_out_status;
   logic key_valid, en_key, en_cipher, en_decipher, aes128_mode, aes256_mode;
   logic [255:0] aes_key;
   logic [127:0] aes_in_blk, aes_out_blk;
   logic en_o, aes_op_in_progress;

   int checks = 0, errors = 0, viol = 0;
   logic m_kv = 1'b0, m_loaded = 1'b0, m_mode = 1'b0;
   logic [255:0] m_key = '0;

   logic core_busy, core_en_o, prev_busy, core_mode;
   logic force_busy = 1'b0, stub_hang = 1'b0, spur_en_o = 1'b0;
   logic [127:0] spur_blk = '0, core_res, core_out;
   logic [255:0] core_key;
   int unsigned stub_lat = 1, core_cnt;

   always #5 clk = ~clk;

   aes_cmd_sequencer dut (
      .clk(clk), .reset(reset), .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
      .s_cmd_op(s_cmd_op), .s_cmd_mode(s_cmd_mode), .s_cmd_data(s_cmd_data),
      .m_out_valid(m_out_valid), .m_out_ready(m_out_ready), .m_out_data(m_out_data),
      .m_out_status(m_out_status), .key_valid(key_valid), .en_key(en_key),
      .en_cipher(en_cipher), .en_decipher(en_decipher), .aes128_mode(aes128_mode),
      .aes256_mode(aes256_mode), .aes_key(aes_key), .aes_in_blk(aes_in_blk),
      .aes_out_blk(aes_out_blk), .en_o(en_o), .aes_op_in_progress(aes_op_in_progress));

   // Core behaviour: known-answer vectors, otherwise an invertible keyed scramble
   function automatic logic [127:0] core_fn(input logic [255:0] k, input logic m,
                                            input logic [127:0] b, input logic dec);
      logic [127:0] t;
      if (!m && k == {128'h0, K128} && !dec && b == PT) return CT128;
      if (!m && k == {128'h0, K128} && dec && b == CT128) return PT;
      if (m && k == K256 && !dec && b == PT) return CT256;
      if (m && k == K256 && dec && b == CT256) return PT;
      if (!dec) begin
         t = m ? (b ^ k[255:128]) : b;
         return {t[63:0], t[127:64]} ^ k[127:0] ^ MIXC;
      end
      t = b ^ k[127:0] ^ MIXC;
      t = {t[63:0], t[127:64]};
      return m ? (t ^ k[255:128]) : t;
   endfunction

   function automatic logic [255:0] rnd256();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   assign aes_op_in_progress = core_busy | force_busy;
   assign en_o        = core_en_o | spur_en_o;
   assign aes_out_blk = spur_en_o ? spur_blk : core_out;

   // Stub core sharing the reset net; flags overlapping, non-one-hot or malformed requests
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         core_busy <= 1'b0; core_en_o <= 1'b0; core_cnt <= 0; prev_busy <= 1'b0;
         core_key <= '0; core_mode <= 1'b0; core_res <= '0; core_out <= '0;
      end else begin
         prev_busy <= aes_op_in_progress;
         core_en_o <= 1'b0;
         if ($countones({en_key, en_cipher, en_decipher}) > 1) viol <= viol + 1;
         if ((en_key | en_cipher | en_decipher) && (prev_busy || core_busy)) viol <= viol + 1;
         if (en_key && (aes128_mode == aes256_mode)) viol <= viol + 1;
         if (en_key | en_cipher | en_decipher) begin
            core_busy <= 1'b1;
            core_cnt  <= stub_lat;
            if (en_key) begin
               core_key <= aes_key; core_mode <= aes256_mode; core_res <= '0;
            end else begin
               core_res <= core_fn(core_key, core_mode, aes_in_blk, en_decipher);
            end
         end else if (core_busy && !stub_hang) begin
            if (core_cnt <= 1) begin
               core_en_o <= 1'b1; core_out <= core_res; core_busy <= 1'b0;
            end else begin
               core_cnt <= core_cnt - 1;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, 256'(s_cmd_ready), 256'(0));
      chk({tag, "_valid"}, 256'(m_out_valid), 256'(0));
      chk({tag, "_data"}, 256'(m_out_data), 256'(0));
      chk({tag, "_status"}, 256'(m_out_status), 256'(0));
      chk({tag, "_key_valid"}, 256'(key_valid), 256'(0));
      chk({tag, "_strobes"}, 256'({en_key, en_cipher, en_decipher}), 256'(0));
      chk({tag, "_modes"}, 256'({aes128_mode, aes256_mode}), 256'(0));
      chk({tag, "_key"}, aes_key, 256'(0));
      chk({tag, "_blk"}, 256'(aes_in_blk), 256'(0));
   endtask

   task automatic wait_ready();
      int n = 0;
      while (s_cmd_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      chk("cmd_ready_idle", 256'(s_cmd_ready), 256'(1));
   endtask

   task automatic do_cmd(input logic [1:0] op, input logic md, input logic [255:0] d,
                         input int lat, input int bcyc, input int bp, input bit hang, input bit spur);
      logic [1:0] exp_st;
      logic [127:0] exp_d;
      logic [2:0] exp_stb, stb_seen;
      logic is_err;
      int s_idx, v_idx, nstb, rdy_bad, hold_bad;
      exp_d = '0; exp_st = 2'd0; is_err = 1'b0; exp_stb = 3'b000;
      if (op == 2'd3) begin
         exp_st = 2'd2; is_err = 1'b1;
      end else if (op != 2'd0 && !m_kv) begin
         exp_st = 2'd1; is_err = 1'b1;
      end else begin
         exp_stb = (op == 2'd0) ? 3'b001 : (op == 2'd1) ? 3'b010 : 3'b100;
         if (op == 2'd0) begin m_loaded = 1'b1; m_mode = md; m_key = d; m_kv = 1'b0; end
         if (hang) begin exp_st = 2'd3; m_kv = 1'b0; end
         else if (op == 2'd0) m_kv = 1'b1;
         else exp_d = core_fn(m_key, m_mode, d[127:0], op == 2'd2);
      end
      stub_lat = lat; stub_hang = hang;
      wait_ready();
      s_cmd_valid = 1'b1; s_cmd_op = op; s_cmd_mode = md; s_cmd_data = d;
      force_busy = (bcyc > 0);
      @(posedge clk);
      s_idx = 0; v_idx = 0; nstb = 0; rdy_bad = 0; stb_seen = 3'b000;
      for (int i = 1; i <= 300 && v_idx == 0; i++) begin
         @(negedge clk);
         if (i == 1) begin
            s_cmd_valid = 1'b0; s_cmd_data = rnd256(); s_cmd_mode = ~md;
            if (op == 2'd0) chk("key_valid_cleared", 256'(key_valid), 256'(0));
         end
         if ({en_key, en_cipher, en_decipher} != 3'b000) begin
            nstb++; stb_seen |= {en_decipher, en_cipher, en_key};
            if (s_idx == 0) s_idx = i;
         end
         if (s_cmd_ready) rdy_bad++;
         if (m_out_valid) v_idx = i;
         if (i == bcyc) force_busy = 1'b0;
      end
      force_busy = 1'b0;
      chk("resp_seen", 256'(v_idx != 0), 256'(1));
      if (is_err) begin
         chk("err_latency", 256'(v_idx), 256'(1));
      end else begin
         chk("strobe_latency", 256'(s_idx), 256'(bcyc + 1));
         if (hang) chk("timeout_cycles", 256'(v_idx - s_idx), 256'(TO + 1));
         else chk("resp_latency", 256'(v_idx - s_idx), 256'(lat + 2));
      end
      chk("strobe_count", 256'(nstb), 256'(is_err ? 0 : 1));
      chk("strobe_kind", 256'(stb_seen), 256'(exp_stb));
      chk("status", 256'(m_out_status), 256'(exp_st));
      chk("data", 256'(m_out_data), 256'(exp_d));
      chk("key_valid", 256'(key_valid), 256'(m_kv));
      chk("modes", 256'({aes128_mode, aes256_mode}), 256'({m_loaded & ~m_mode, m_loaded & m_mode}));
      chk("ready_low_busy", 256'(rdy_bad), 256'(0));
      hold_bad = 0;
      for (int k = 0; k < bp; k++) begin
         if (spur && k == 0) begin spur_blk = rnd256()[127:0]; spur_en_o = 1'b1; end
         @(negedge clk);
         spur_en_o = 1'b0;
         if (m_out_valid !== 1'b1 || m_out_data !== exp_d || m_out_status !== exp_st || s_cmd_ready !== 1'b0)
            hold_bad++;
      end
      chk("resp_hold", 256'(hold_bad), 256'(0));
      m_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      m_out_ready = 1'b0;
      chk("ready_after_resp", 256'(s_cmd_ready), 256'(1));
      chk("valid_dropped", 256'(m_out_valid), 256'(0));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int r, bad;
      logic [1:0] op;
      repeat (2) @(negedge clk);
      chk_reset_vals("por");
      reset = 1'b1;
      @(negedge clk);
      chk("ready_after_release", 256'(s_cmd_ready), 256'(1));

      do_cmd(2'd1, 1'b0, {128'h0, PT}, 2, 0, 0, 1'b0, 1'b0);            // NOKEY
      do_cmd(2'd3, 1'b0, rnd256(), 2, 0, 0, 1'b0, 1'b0);                 // BADOP
      do_cmd(2'd0, 1'b0, {128'h0, K128}, 3, 0, 0, 1'b0, 1'b0);           // AES-128 key
      do_cmd(2'd1, 1'b1, {128'h0, PT}, 4, 3, 0, 1'b0, 1'b0);             // encrypt, core busy 3 cycles
      do_cmd(2'd0, 1'b1, K256, 1, 0, 0, 1'b0, 1'b0);                     // AES-256 key
      do_cmd(2'd1, 1'b0, {128'h0, PT}, 5, 0, 0, 1'b0, 1'b0);
      do_cmd(2'd2, 1'b0, {128'h0, CT256}, 2, 0, 10, 1'b0, 1'b1);         // decrypt + back-pressure
      do_cmd(2'd1, 1'b1, {128'h0, PT}, 2, 0, 2, 1'b1, 1'b0);             // timeout
      stub_hang = 1'b0;
      bad = 0;
      for (int i = 0; i < 12; i++) begin @(negedge clk); if (m_out_valid) bad++; end
      chk("late_en_o_ignored", 256'(bad), 256'(0));
      do_cmd(2'd2, 1'b0, {128'h0, CT256}, 2, 0, 0, 1'b0, 1'b0);          // NOKEY after timeout

      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 9);
         op = (r < 2) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         do_cmd(op, 1'($urandom_range(0, 1)), rnd256(), $urandom_range(1, 6),
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                $urandom_range(0, 3), 1'b0, 1'($urandom_range(0, 1)));
      end

      // Async reset while waiting on a stuck core
      do_cmd(2'd0, 1'b0, {128'h0, K128}, 1, 0, 0, 1'b0, 1'b0);
      stub_hang = 1'b1;
      wait_ready();
      s_cmd_valid = 1'b1; s_cmd_op = 2'd1; s_cmd_data = rnd256();
      @(posedge clk);
      @(negedge clk);
      s_cmd_valid = 1'b0;
      repeat (10) @(negedge clk);
      #2 reset = 1'b0;
      #1 chk_reset_vals("wait_rst");
      m_kv = 1'b0; m_loaded = 1'b0; m_mode = 1'b0; m_key = '0;
      stub_hang = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Async reset on the strobe cycle drops the strobe immediately
      wait_ready();
      s_cmd_valid = 1'b1; s_cmd_op = 2'd0; s_cmd_mode = 1'b1; s_cmd_data = K256;
      @(posedge clk);
      @(negedge clk);
      s_cmd_valid = 1'b0;
      chk("en_key_raised", 256'(en_key), 256'(1));
      #1 reset = 1'b0;
      #1 chk("strobe_async_drop", 256'(en_key), 256'(0));
      chk_reset_vals("strobe_rst");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      do_cmd(2'd0, 1'b1, K256, 2, 0, 0, 1'b0, 1'b0);
      do_cmd(2'd1, 1'b0, {128'h0, PT}, 3, 0, 0, 1'b0, 1'b0);
      chk("core_protocol", 256'(viol), 256'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
